// File: rtl/stim_stream_buffer_pkg.sv
// Shared defaults for the stimulus stream buffer slice.
// Widths here are only defaults; instances may override them.
package stim_stream_buffer_pkg;

    localparam int SSB_DWID  = 16;
    localparam int SSB_DEPTH = 16;
    localparam int SSB_CWID  = 16;
    localparam int SSB_PWID  = 32;

endpackage

// File: rtl/stim_stream_ram.sv
// Storage array for the stimulus stream buffer.
// Synchronous write, asynchronous read for first-word-fall-through.
module stim_stream_ram
    import stim_stream_buffer_pkg::*;
#(
    parameter int DWID  = SSB_DWID,
    parameter int DEPTH = SSB_DEPTH,
    parameter int AWID  = $clog2(DEPTH)
) (
    input  logic            iClk,
    input  logic            iWe,
    input  logic [AWID-1:0] iWaddr,
    input  logic [DWID-1:0] iWdata,
    input  logic [AWID-1:0] iRaddr,
    output logic [DWID-1:0] oRdata
);

    logic [DWID-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[iWaddr] <= iWdata;
        end
    end

    assign oRdata = mem[iRaddr];

endmodule

// File: rtl/stim_stream_buffer.sv
// Elastic buffer from a no-backpressure stimulus reader to a
// valid/ready stream, with sticky overflow and drop counting.
module stim_stream_buffer
    import stim_stream_buffer_pkg::*;
#(
    parameter  int DWID  = SSB_DWID,
    parameter  int DEPTH = SSB_DEPTH,
    parameter  int CWID  = SSB_CWID,
    localparam int AWID  = $clog2(DEPTH)
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iValid,
    input  logic [DWID-1:0] iData,
    output logic            oValid,
    output logic [DWID-1:0] oData,
    input  logic            iReady,
    output logic [AWID:0]   oCount,
    output logic            oFull,
    output logic            oEmpty,
    output logic            oOvf,
    output logic [CWID-1:0] oDropCnt,
    input  logic            iClrOvf,
    output logic [31:0]     oPopCnt
);

    localparam logic [AWID:0] FULL_CNT = (AWID+1)'(DEPTH);

    logic [AWID-1:0] wr_ptr;
    logic [AWID-1:0] rd_ptr;
    logic [AWID:0]   count;
    logic            ovf;
    logic [CWID-1:0] drop_cnt;
    logic [31:0]     pop_cnt;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A pop in the same cycle frees the slot the incoming word needs.
    assign pop  = ~empty & iReady;
    assign push = iValid & (~full | pop);
    assign drop = iValid & full & ~iReady;

    stim_stream_ram #(
        .DWID  (DWID),
        .DEPTH (DEPTH),
        .AWID  (AWID)
    ) u_ram (
        .iClk   (iClk),
        .iWe    (push),
        .iWaddr (wr_ptr),
        .iWdata (iData),
        .iRaddr (rd_ptr),
        .oRdata (oData)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AWID'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AWID'(1);
                pop_cnt <= pop_cnt + 32'd1;
            end
            if (push && !pop) begin
                count <= count + (AWID+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AWID+1)'(1);
            end
        end
    end

    // Clear takes effect first, so a coincident drop is still counted.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (iClrOvf) begin
            ovf      <= drop;
            drop_cnt <= CWID'(drop);
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CWID'(1);
            end
        end
    end

    assign oValid   = ~empty;
    assign oCount   = count;
    assign oFull    = full;
    assign oEmpty   = empty;
    assign oOvf     = ovf;
    assign oDropCnt = drop_cnt;
    assign oPopCnt  = pop_cnt;

endmodule
